// File: rtl/ex_fsm_multi.sv
// Multi-channel level debouncer: 2-flop synchroniser plus a per-channel confirm FSM.
// Optional per-channel rise-event counters are enabled with the EX_FSM_EVT_CNT_EN macro.
//
// state   | meaning
// IDLE_LO | confirmed low, waiting for a_s=1
// CHK_HI  | a_s high, counting toward HOLD before confirming the rise
// IDLE_HI | confirmed high, waiting for a_s=0
// CHK_LO  | a_s low, counting toward HOLD before confirming the fall
module ex_fsm_multi #(
    parameter int CH   = 4,
    parameter int HOLD = 8
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic [CH-1:0] A,
    output logic [CH-1:0] k1,
    output logic [CH-1:0] k2,
    output logic [CH-1:0] level
`ifdef EX_FSM_EVT_CNT_EN
    ,
    output logic [CH*8-1:0] evt_cnt
`endif
);

    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } state_t;

    logic [CH-1:0] a_m;
    logic [CH-1:0] a_s;

    always_ff @(posedge sclk) begin
        if (rst) begin
            a_m <= '0;
            a_s <= '0;
        end else begin
            a_m <= A;
            a_s <= a_m;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t        st, st_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          k1_q, k2_q, lvl_q;
        logic          k1_nxt, k2_nxt, lvl_nxt;

        always_ff @(posedge sclk) begin
            if (rst) begin
                st    <= IDLE_LO;
                cnt   <= '0;
                k1_q  <= 1'b0;
                k2_q  <= 1'b0;
                lvl_q <= 1'b0;
            end else begin
                st    <= st_nxt;
                cnt   <= cnt_nxt;
                k1_q  <= k1_nxt;
                k2_q  <= k2_nxt;
                lvl_q <= lvl_nxt;
            end
        end

        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            k1_nxt  = 1'b0;
            k2_nxt  = 1'b0;
            lvl_nxt = lvl_q;
            case (st)
                IDLE_LO: begin
                    if (a_s[i]) begin
                        st_nxt  = CHK_HI;
                        cnt_nxt = CW'(1);
                    end
                end
                CHK_HI: begin
                    if (!a_s[i]) begin
                        st_nxt  = IDLE_LO;
                        cnt_nxt = '0;
                    end else if (cnt == CW'(HOLD)) begin
                        st_nxt  = IDLE_HI;
                        cnt_nxt = '0;
                        k1_nxt  = 1'b1;
                        lvl_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                IDLE_HI: begin
                    if (!a_s[i]) begin
                        st_nxt  = CHK_LO;
                        cnt_nxt = CW'(1);
                    end
                end
                CHK_LO: begin
                    if (a_s[i]) begin
                        st_nxt  = IDLE_HI;
                        cnt_nxt = '0;
                    end else if (cnt == CW'(HOLD)) begin
                        st_nxt  = IDLE_LO;
                        cnt_nxt = '0;
                        k2_nxt  = 1'b1;
                        lvl_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    st_nxt  = IDLE_LO;
                    cnt_nxt = '0;
                end
            endcase
        end

        assign k1[i]    = k1_q;
        assign k2[i]    = k2_q;
        assign level[i] = lvl_q;

`ifdef EX_FSM_EVT_CNT_EN
        logic [7:0] ev;

        // Counts alongside the k1 register so evt_cnt and k1 update together.
        always_ff @(posedge sclk) begin
            if (rst) begin
                ev <= '0;
            end else if (k1_nxt && (ev != 8'hFF)) begin
                ev <= ev + 8'd1;
            end
        end

        assign evt_cnt[8*i +: 8] = ev;
`endif
    end

endmodule

// File: tb/tb_ex_fsm_multi.sv
// Directed bench for ex_fsm_multi (CH=4, HOLD=8): vector table plus hand-written
// sequences for latency, glitch length, simultaneous rise and reset abort.
module tb_ex_fsm_multi;

    localparam int CH   = 4;
    localparam int HOLD = 8;
    localparam int LAT  = HOLD + 2;

    logic          tb_sclk = 1'b0;
    logic          rst;
    logic [CH-1:0] A;
    logic [CH-1:0] k1;
    logic [CH-1:0] k2;
    logic [CH-1:0] level;
`ifdef EX_FSM_EVT_CNT_EN
    logic [CH*8-1:0] evt_cnt;
`endif

    ex_fsm_multi #(.CH(CH), .HOLD(HOLD)) dut (
        .sclk   (tb_sclk),
        .rst    (rst),
        .A      (A),
        .k1     (k1),
        .k2     (k2),
        .level  (level)
`ifdef EX_FSM_EVT_CNT_EN
        ,
        .evt_cnt(evt_cnt)
`endif
    );

    always #5 tb_sclk = ~tb_sclk;

    typedef struct {
        logic [3:0] a;
        int         cycles;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl [12];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   overlap = 1'b0;
    int   rise_cnt [CH];
    int   fall_cnt [CH];

    // One clock edge, then observe outputs 1 ns later.
    task automatic tick();
        @(posedge tb_sclk);
        #1;
        if ((k1 & k2) != '0) overlap = 1'b1;
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] += int'(k1[c]);
            fall_cnt[c] += int'(k2[c]);
        end
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A has just been changed; the next edge is the first sampling edge (index 0).
    task automatic measure(input int ch, input bit rise, input string name);
        int first = -1;
        int width = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (rise ? k1[ch] : k2[ch]) begin
                if (first < 0) first = n;
                width++;
            end
        end
        check({name, "_latency"}, 32'(first), 32'(LAT));
        check({name, "_width"}, 32'(width), 32'd1);
    endtask

    initial begin
        int         snap_r [CH];
        int         snap_f [CH];
        logic [15:0] got_r, got_f, exp_r, exp_f;
        int         found;

        tbl[0]  = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 250, 4'b0001, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b0001};
        tbl[3]  = '{4'b0010,   5, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1111,  20, 4'b1111, 4'b1111, 4'b0000};
        tbl[6]  = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b1111};
        tbl[7]  = '{4'b0101,  20, 4'b0101, 4'b0101, 4'b0000};
        tbl[8]  = '{4'b1010,  20, 4'b1010, 4'b1010, 4'b0101};
        tbl[9]  = '{4'b0010,   3, 4'b1010, 4'b0000, 4'b0000};
        tbl[10] = '{4'b1010,  20, 4'b1010, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0000,  20, 4'b0000, 4'b0000, 4'b1010};

        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end

        rst = 1'b1;
        A   = '0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check("reset_outputs", 32'({k1, k2, level}), 32'd0);
        end
`ifdef EX_FSM_EVT_CNT_EN
        check("reset_evt_cnt", evt_cnt, 32'd0);
`endif
        rst = 1'b0;

        for (int s = 0; s < 12; s++) begin
            for (int c = 0; c < CH; c++) begin
                snap_r[c] = rise_cnt[c];
                snap_f[c] = fall_cnt[c];
            end
            A = tbl[s].a;
            ticks(tbl[s].cycles);
            for (int c = 0; c < CH; c++) begin
                got_r[4*c +: 4] = 4'(rise_cnt[c] - snap_r[c]);
                got_f[4*c +: 4] = 4'(fall_cnt[c] - snap_f[c]);
                exp_r[4*c +: 4] = {3'b000, tbl[s].rise[c]};
                exp_f[4*c +: 4] = {3'b000, tbl[s].fall[c]};
            end
            check($sformatf("vec%0d_level", s), 32'(level), 32'(tbl[s].lvl));
            check($sformatf("vec%0d_k1_count", s), 32'(got_r), 32'(exp_r));
            check($sformatf("vec%0d_k2_count", s), 32'(got_f), 32'(exp_f));
        end

        // Rise/fall latency and pulse width on channel 0.
        A = 4'b0001;
        measure(0, 1'b1, "ch0_rise");
        check("ch0_level_hi", 32'(level), 32'h1);
        A = 4'b0000;
        measure(0, 1'b0, "ch0_fall");
        check("ch0_level_lo", 32'(level), 32'h0);

        // Eight sampled cycles is one short of confirming; nine confirms.
        snap_r[1] = rise_cnt[1];
        A = 4'b0010;
        ticks(8);
        A = 4'b0000;
        ticks(20);
        check("ch1_short8_k1", 32'(rise_cnt[1] - snap_r[1]), 32'd0);
        check("ch1_short8_level", 32'(level), 32'h0);
        snap_r[1] = rise_cnt[1];
        snap_f[1] = fall_cnt[1];
        A = 4'b0010;
        ticks(9);
        A = 4'b0000;
        ticks(20);
        check("ch1_exact9_k1", 32'(rise_cnt[1] - snap_r[1]), 32'd1);
        check("ch1_exact9_k2", 32'(fall_cnt[1] - snap_f[1]), 32'd1);

        // All channels rise together.
        A = 4'b1111;
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            tick();
            if (k1 != '0) begin
                found = 1;
                check("all_rise_k1", 32'(k1), 32'hF);
                check("all_rise_k2", 32'(k2), 32'h0);
            end
        end
        check("all_rise_seen", 32'(found), 32'd1);
        ticks(20);
        A = 4'b0000;
        ticks(30);

        // Reset while channel 2 is at count 4, then re-rise from the held input.
        snap_r[2] = rise_cnt[2];
        A = 4'b0100;
        ticks(6);
        rst = 1'b1;
        ticks(2);
        check("rst_abort_outputs", 32'({k1, level}), 32'd0);
        check("rst_abort_k1_count", 32'(rise_cnt[2] - snap_r[2]), 32'd0);
        rst = 1'b0;
        measure(2, 1'b1, "ch2_after_rst");
        check("ch2_after_rst_level", 32'(level), 32'h4);
        A = 4'b0000;
        ticks(30);

`ifdef EX_FSM_EVT_CNT_EN
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        for (int r = 0; r < 300; r++) begin
            A = 4'b0001;
            ticks(13);
            A = 4'b0000;
            ticks(13);
            if (r == 99) check("evt_cnt_100", evt_cnt, 32'd100);
        end
        check("evt_cnt_saturated", evt_cnt, 32'h0000_00FF);
`endif

        check("k1_k2_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_fsm_multi.md
EX_FSM_MULTI -- requirements
Module: ex_fsm_multi

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 Parameter HOLD, default 8: consecutive synchronised cycles a new input level must persist before it is confirmed, legal range 1..255.
REQ-003 sclk  input  1  single clock; all logic rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 A  input  CH  asynchronous per-channel level inputs.
REQ-006 k1  output  CH  per-channel one-cycle pulse on confirmed 0->1 transition.
REQ-007 k2  output  CH  per-channel one-cycle pulse on confirmed 1->0 transition.
REQ-008 level  output  CH  per-channel debounced (confirmed) level.
REQ-009 evt_cnt  output  CH*8  per-channel rise-event counter, channel i at bits [8i+7:8i]; present only with EX_FSM_EVT_CNT_EN.

Function
REQ-010 Each channel passes A[i] through a 2-flop synchroniser; a_s[i] denotes the second flop.
REQ-011 Each channel runs its own 4-state FSM: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO; channels share no state.
REQ-012 IDLE_LO: a_s=1 -> CHK_HI with counter loaded to 1; else stay.
REQ-013 CHK_HI: a_s=0 -> IDLE_LO, counter cleared, no pulse; a_s=1 and counter=HOLD -> IDLE_HI, k1 pulse, level set to 1; else counter increments.
REQ-014 IDLE_HI / CHK_LO: mirror of REQ-012/013 with polarity inverted, k2 pulse, level cleared to 0.
REQ-015 HOLD=1: transition confirmed on the cycle after the first a_s cycle at the new value.
REQ-016 Latency: k1/k2 rise exactly HOLD+2 sclk edges after the first edge sampling the new A value, held stable thereafter; pulse width exactly one cycle.
REQ-017 Glitch shorter than HOLD synchronised cycles produces no pulse and no change of level.
REQ-018 k1 and k2 of one channel never assert in the same cycle; different channels may pulse simultaneously.
REQ-019 Counter width clog2(HOLD+1) bits; counter never exceeds HOLD.
REQ-020 Outputs k1, k2, level are registered; no combinational path from A to any output.

Reset
REQ-021 While rst=1 on a sclk edge: all FSMs -> IDLE_LO, counters 0, synchroniser flops 0, level=0, k1=0, k2=0, evt_cnt=0.
REQ-022 Reset asserted mid-check aborts the pending transition with no pulse.
REQ-023 If A[i]=1 when rst deasserts, channel i treats it as a new rise and pulses k1 after the REQ-016 latency.

Configuration
REQ-024 Macro EX_FSM_EVT_CNT_EN defined: evt_cnt present; channel counter increments by 1 on each k1 pulse, saturates at 255, cleared only by rst.
REQ-025 Macro EX_FSM_EVT_CNT_EN undefined: evt_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-026 CH=4, HOLD=8: rst 5 cycles, A=0 -> k1=k2=0, level=0 throughout.
REQ-027 A[0] 0->1 held 250 cycles -> single k1[0] pulse 10 edges after sampling edge, level[0]=1; A[0] 1->0 -> single k2[0] 10 edges later, level[0]=0.
REQ-028 A[1] high for 5 cycles then low -> no k1[1], level[1] stays 0; high for exactly 9 sampled cycles -> k1[1] fires.
REQ-029 A[3:0] all rise same cycle -> k1=4'b1111 in one cycle, k2=0.
REQ-030 A[2]=1, rst asserted during CHK_HI count 4 -> no pulse; after rst release, k1[2] 10 edges later.
REQ-031 With EX_FSM_EVT_CNT_EN: 300 confirmed rises on channel 0 -> evt_cnt[7:0]=255, other channels 0.
